// File: rtl/ifetch_buffer.sv
// Instruction queue between ifetch and decode: {PC, instruction} FIFO with an early stall
// that leaves one skid slot. Optional same-cycle bypass on an empty queue: IFETCH_BUFFER_BYPASS_EN.
module ifetch_buffer #(
  parameter int unsigned    DEPTH = 4,
  parameter int unsigned    AW    = 16,
  parameter int unsigned    DW    = 32,
  parameter logic [DW-1:0]  NOP   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] inst_i,
  input  logic [AW-1:0] inst_addr_i,
  input  logic          valid_i,
  input  logic          flush_i,
  input  logic          stall_i,
  output logic          stall_o,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          valid_o,
  output logic          overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CountFull = CW'(DEPTH);
  localparam logic [CW-1:0] CountSkid = CW'(DEPTH - 1);

  logic [AW+DW-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;

  logic empty, full, pop, push, drop;

  assign empty = (count == '0);
  assign full  = (count == CountFull);
  assign pop   = !empty && !stall_i && !flush_i;
  assign drop  = valid_i && !flush_i && full && !pop;

`ifdef IFETCH_BUFFER_BYPASS_EN
  logic bypass;
  assign bypass = empty && valid_i && !flush_i;
  // A bypassed word that decode accepts this cycle never enters the queue.
  assign push   = valid_i && !flush_i && (!full || pop) && !(bypass && !stall_i);
`else
  assign push   = valid_i && !flush_i && (!full || pop);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {inst_addr_i, inst_i};
  end

  always_comb begin
    inst_o      = NOP;
    inst_addr_o = '0;
    valid_o     = 1'b0;
    if (!empty) begin
      {inst_addr_o, inst_o} = mem[rd_ptr];
      valid_o               = 1'b1;
    end
`ifdef IFETCH_BUFFER_BYPASS_EN
    if (bypass) begin
      inst_o      = inst_i;
      inst_addr_o = inst_addr_i;
      valid_o     = 1'b1;
    end
`endif
  end

  assign stall_o    = (count >= CountSkid);
  assign overflow_o = overflow;

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed self-checking bench for ifetch_buffer (default build, no bypass).
module tb_ifetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [15:0] inst_addr_i;
  logic        valid_i, flush_i, stall_i;
  logic        stall_o, valid_o, overflow_o;
  logic [31:0] inst_o;
  logic [15:0] inst_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ifetch_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .valid_i     (valid_i),
    .flush_i     (flush_i),
    .stall_i     (stall_i),
    .stall_o     (stall_o),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .valid_o     (valid_o),
    .overflow_o  (overflow_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] a);
    valid_i     = v;
    inst_addr_i = a;
    inst_i      = {16'hC0DE, a};
  endtask

  task automatic check_head(input string tag, input logic [15:0] a);
    check_val({tag, "_valid"}, 32'(valid_o), 32'd1);
    check_val({tag, "_addr"}, 32'(inst_addr_o), 32'(a));
    check_val({tag, "_inst"}, inst_o, {16'hC0DE, a});
  endtask

  task automatic check_empty(input string tag);
    check_val({tag, "_valid"}, 32'(valid_o), 32'd0);
    check_val({tag, "_nop"}, inst_o, 32'h0);
    check_val({tag, "_addr0"}, 32'(inst_addr_o), 32'h0);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    drive(1'b1, 16'h0abc);
    tick(); tick();
    check_empty("reset");
    check_val("reset_stall", 32'(stall_o), 32'd0);
    check_val("reset_ovf", 32'(overflow_o), 32'd0);

    // First push after reset appears one cycle later.
    rst = 1'b0; stall_i = 1'b1;
    drive(1'b1, 16'h0050);
    #1;
    check_val("first_push_latency", 32'(valid_o), 32'd0);
    tick();
    check_head("first_push", 16'h0050);
    drive(1'b0, 16'h0); stall_i = 1'b0;
    tick();
    check_empty("first_drain");

    // Streaming: one in, one out every cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'(i));
      tick();
      check_head("stream", 16'(i));
      check_val("stream_stall", 32'(stall_o), 32'd0);
    end
    drive(1'b0, 16'h0);
    tick();
    check_empty("stream_end");

    // Back-pressure with skid slot.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h0010 + i));
      tick();
      check_val("bp_stall", 32'(stall_o), (i >= 2) ? 32'd1 : 32'd0);
    end
    check_val("bp_ovf", 32'(overflow_o), 32'd0);
    drive(1'b0, 16'h0); stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_head("bp_drain", 16'(16'h0010 + i));
      tick();
    end
    check_empty("bp_end");

    // Full queue with simultaneous push and pop.
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h0030 + i));
      tick();
    end
    stall_i = 1'b0;
    drive(1'b1, 16'h0034);
    tick();
    check_head("full_pp", 16'h0031);
    check_val("full_pp_stall", 32'(stall_o), 32'd1);
    check_val("full_pp_ovf", 32'(overflow_o), 32'd0);
    drive(1'b0, 16'h0);
    for (int i = 1; i < 5; i++) begin
      check_head("full_drain", 16'(16'h0030 + i));
      tick();
    end
    check_empty("full_end");

    // Flush discards contents and same-cycle push.
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(16'h0020 + i));
      tick();
    end
    check_val("pre_flush_stall", 32'(stall_o), 32'd1);
    flush_i = 1'b1;
    drive(1'b1, 16'h0023);
    tick();
    flush_i = 1'b0;
    drive(1'b0, 16'h0);
    check_empty("flush");
    check_val("flush_stall", 32'(stall_o), 32'd0);
    drive(1'b1, 16'h0100);
    tick();
    drive(1'b0, 16'h0);
    check_head("post_flush", 16'h0100);
    check_val("post_flush_stall", 32'(stall_o), 32'd0);
    stall_i = 1'b0;
    tick();
    check_empty("post_flush_drain");

    // Overflow: fifth push while full is dropped and sticky.
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(16'h0040 + i));
      tick();
    end
    check_val("ovf_set", 32'(overflow_o), 32'd1);
    drive(1'b0, 16'h0); stall_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_head("ovf_drain", 16'(16'h0040 + i));
      tick();
    end
    check_empty("ovf_fifth_dropped");
    check_val("ovf_sticky", 32'(overflow_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("ovf_cleared", 32'(overflow_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
